load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_if.sv | 34 +++
 rtl/load_store_unit.sv | 97 +++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request/response and data-RAM bundle for load_store_unit
// Ports (via modports):
//   req_valid/req_write/req_addr/req_len/req_wdata/req_ready : burst request handshake
//   resp_valid/resp_rdata/done                               : read beats and end-of-burst pulse
//   ram_we/ram_addr/ram_wdata/ram_rdata                      : synchronous data RAM port
// master = requester plus RAM side, slave = the load/store unit.
interface load_store_unit_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [3:0]        req_len;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              done;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_len, req_wdata, ram_rdata,
    input  req_ready, resp_valid, resp_rdata, done, ram_we, ram_addr, ram_wdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_len, req_wdata, ram_rdata,
    output req_ready, resp_valid, resp_rdata, done, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - burst fill / burst read engine in front of a synchronous data RAM
// Ports:
//   clk  : single rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : load_store_unit_if.slave (request handshake, read response, done pulse, RAM port)
module load_store_unit #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input logic               clk,
  input logic               rst,
  load_store_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t            state, next_state;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] addr_hold;   // last address driven, held on ram_addr between bursts
  logic [3:0]        count;       // beats remaining after the current one
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] wdata_hold;  // last fill byte driven, held on ram_wdata between bursts
  logic              rd_pend;     // an address was issued last cycle; its data is on ram_rdata now

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state    = state;
    bus.req_ready = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_addr  = addr_hold;
    bus.ram_wdata = wdata_hold;
    bus.done      = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) next_state = bus.req_write ? WRITE : READ;
      end
      WRITE: begin
        bus.ram_we    = 1'b1;
        bus.ram_addr  = cur_addr;
        bus.ram_wdata = wdata_reg;
        if (count == 4'd0) begin
          bus.done   = 1'b1;
          next_state = IDLE;
        end
      end
      READ: begin
        bus.ram_addr = cur_addr;
        if (count == 4'd0) next_state = DRAIN;
      end
      DRAIN: begin
        // final address was issued last cycle; its beat is presented now
        bus.done   = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Read data comes straight from the RAM's registered output, gated to zero when no beat is due.
  assign bus.resp_valid = rd_pend;
  assign bus.resp_rdata = rd_pend ? bus.ram_rdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_addr   <= '0;
      addr_hold  <= '0;
      count      <= '0;
      wdata_reg  <= '0;
      wdata_hold <= '0;
      rd_pend    <= 1'b0;
    end else begin
      rd_pend <= (state == READ);
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            cur_addr  <= bus.req_addr;
            count     <= bus.req_len;
            wdata_reg <= bus.req_wdata;
          end
        end
        WRITE, READ: begin
          cur_addr  <= cur_addr + ADDR_W'(1);  // wraps modulo 2^ADDR_W
          addr_hold <= cur_addr;
          if (count != 4'd0) count <= count - 4'd1;
          if (state == WRITE) wdata_hold <= wdata_reg;
        end
        default: ;
      endcase
    end
  end

endmodule
